// File: rtl/gray2bin_pipe.sv
// gray2bin_pipe: pipelined Gray-to-binary decoder with valid/ready on both sides.
// The prefix-XOR chain is cut into STAGE_NUM register stages, MSB chunk first.
// Each stage register holds one word whose upper bits are already binary and
// whose lower bits are still raw Gray; the next stage resolves the next chunk.
// Optional feature macro: GRAY2BIN_PIPE_CHECK_EN (sticky Gray-distance error flag).
module gray2bin_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGE_NUM  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] gray_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] bin_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o
);

  // Number of bits each stage resolves; trailing stages may have nothing to do.
  localparam int CHUNK = (DATA_WIDTH + STAGE_NUM - 1) / STAGE_NUM;

  logic [DATA_WIDTH-1:0] stage_data [STAGE_NUM];
  logic [STAGE_NUM-1:0]  stage_valid;
  logic [DATA_WIDTH-1:0] src_data   [STAGE_NUM];
  logic [STAGE_NUM-1:0]  src_valid;
  logic [DATA_WIDTH-1:0] stage_res  [STAGE_NUM];
  logic [STAGE_NUM:0]    stage_load;

  // Load enables ripple back from the sink: a stage loads when empty or draining.
  always_comb begin
    stage_load = '0;
    stage_load[STAGE_NUM] = ready_i;
    for (int k = STAGE_NUM - 1; k >= 0; k--) begin
      stage_load[k] = !stage_valid[k] || stage_load[k+1];
    end
  end

  // Each stage is fed by the input port (stage 0) or the preceding stage register.
  always_comb begin
    src_data[0]  = gray_i;
    src_valid    = '0;
    src_valid[0] = valid_i;
    for (int k = 1; k < STAGE_NUM; k++) begin
      src_data[k]  = stage_data[k-1];
      src_valid[k] = stage_valid[k-1];
    end
  end

  // Resolve this stage's chunk MSB-first; the bit above a chunk is already binary.
  always_comb begin
    for (int k = 0; k < STAGE_NUM; k++) begin
      stage_res[k] = src_data[k];
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
        if ((i <= DATA_WIDTH - 1 - k * CHUNK) && (i >= DATA_WIDTH - (k + 1) * CHUNK)) begin
          stage_res[k][i] = stage_res[k][i+1] ^ src_data[k][i];
        end
      end
    end
  end

  // Stage registers: reset wins, otherwise load when allowed; data only moves with a valid word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_valid <= '0;
      for (int k = 0; k < STAGE_NUM; k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGE_NUM; k++) begin
        if (stage_load[k]) begin
          stage_valid[k] <= src_valid[k];
          if (src_valid[k]) begin
            stage_data[k] <= stage_res[k];
          end
        end
      end
    end
  end

  assign ready_o = stage_load[0];
  assign valid_o = stage_valid[STAGE_NUM-1];
  assign bin_o   = stage_data[STAGE_NUM-1];

`ifdef GRAY2BIN_PIPE_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] prev_gray;
  logic [DATA_WIDTH-1:0] gray_diff;
  logic                  seen_first;
  logic                  err_q;
  logic                  take_in;

  assign take_in   = valid_i && ready_o;
  assign gray_diff = gray_i ^ prev_gray;

  // Track the last accepted Gray word; more than one flipped bit sets a sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_gray  <= '0;
      seen_first <= 1'b0;
      err_q      <= 1'b0;
    end else if (take_in) begin
      prev_gray  <= gray_i;
      seen_first <= 1'b1;
      if (seen_first && (|(gray_diff & (gray_diff - ONE)))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
